// File: rtl/dp_mem_responder.sv
// Datapath-side memory responder: arbitrates fetch and data requests
// onto one RAM port and returns registered loads with one-cycle hits.
module dp_mem_responder #(
   parameter int WORD_W      = 32,
   parameter int RAM_TIMEOUT = 64,
   parameter int CNT_W       = 7
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   input  logic              dmemREN,
   input  logic              dmemWEN,
   input  logic [WORD_W-1:0] dmemaddr,
   input  logic [WORD_W-1:0] dmemstore,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   output logic              dhit,
   output logic [WORD_W-1:0] dmemload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              mem_err
);

   typedef enum logic [2:0] {
      IDLE,
      DACC,
      IACC,
      DONE,
      ERR
   } state_t;

   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_TIMEOUT - 1);

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic             is_wr;
   logic             src_d;
   logic             dreq;
   logic             req_live;
   logic             unused_bits;

   assign dreq        = dmemREN | dmemWEN;
   assign unused_bits = ^{imemaddr[1:0], dmemaddr[1:0]};

   // The request that started the access must stay up, or it is abandoned.
   always_comb begin
      req_live = 1'b0;
      case (state)
         DACC:    req_live = is_wr ? dmemWEN : dmemREN;
         IACC:    req_live = imemREN;
         default: req_live = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (dreq) begin
               next_state = DACC;
            end else if (imemREN) begin
               next_state = IACC;
            end
         end
         DACC, IACC: begin
            if (!req_live) begin
               next_state = IDLE;
            end else if (ramstate == RS_ACCESS) begin
               next_state = DONE;
            end else if (ramstate == RS_ERROR || cnt == CNT_LAST) begin
               next_state = ERR;
            end
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = ERR;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      ramREN  = (state == DACC && !is_wr) || state == IACC;
      ramWEN  = state == DACC && is_wr;
      dhit    = state == DONE && src_d;
      ihit    = state == DONE && !src_d;
      mem_err = state == ERR;
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt      <= '0;
         is_wr    <= 1'b0;
         src_d    <= 1'b0;
         ramaddr  <= '0;
         ramstore <= '0;
         imemload <= '0;
         dmemload <= '0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (dreq) begin
                  src_d    <= 1'b1;
                  is_wr    <= dmemWEN;
                  ramaddr  <= {dmemaddr[WORD_W-1:2], 2'b00};
                  ramstore <= dmemstore;
               end else if (imemREN) begin
                  src_d    <= 1'b0;
                  is_wr    <= 1'b0;
                  ramaddr  <= {imemaddr[WORD_W-1:2], 2'b00};
                  ramstore <= dmemstore;
               end
            end
            DACC, IACC: begin
               cnt <= cnt + 1'b1;
               if (next_state == DONE) begin
                  if (state == IACC) begin
                     imemload <= ramload;
                  end else if (!is_wr) begin
                     dmemload <= ramload;
                  end
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Responder side of the datapath-to-cache request interface: accepts instruction-fetch and data load/store requests from the pipelined datapath and serves them over a single shared RAM port.
- Arbitrates between the two request sources, sequences each RAM access, returns load data and issues single-cycle ihit/dhit pulses.
- Sits between the datapath and the RAM model in place of a cache during bring-up. Later caches must present the same datapath-side behaviour.

Parameters:
- WORD_W, 32, data and address width in bits
- RAM_TIMEOUT, 64, max cycles a RAM access may stay un-ACCESSed before being declared an error
- CNT_W, 7, width of the timeout counter; must satisfy 2^CNT_W > RAM_TIMEOUT

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  reset, asynchronous, active-low
- imemREN  in  1  instruction read request, level, held until ihit
- imemaddr  in  WORD_W  instruction address
- dmemREN  in  1  data read request, level, held until dhit
- dmemWEN  in  1  data write request, level, held until dhit
- dmemaddr  in  WORD_W  data address
- dmemstore  in  WORD_W  data to store
- ihit  out  1  one-cycle pulse: imemload valid / fetch complete
- imemload  out  WORD_W  fetched instruction, registered
- dhit  out  1  one-cycle pulse: data access complete
- dmemload  out  WORD_W  loaded data, registered
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address, word-aligned
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- mem_err  out  1  sticky error flag

Behaviour:
- Reset (nRST low, any cycle, including mid-access): state=IDLE. ihit, dhit, ramREN, ramWEN and mem_err are 0. imemload, dmemload, ramaddr and ramstore are 0. Timeout counter is 0.
- States: IDLE, DACC, IACC, DONE, ERR.
- IDLE:
  - If dmemREN|dmemWEN, go to DACC (data has priority over instruction).
  - Else if imemREN, go to IACC.
  - Else stay in IDLE.
  - Latch the selected address {addr[WORD_W-1:2],2'b00} and dmemstore into the RAM-side registers at this transition.
- dmemREN and dmemWEN both high: treated as a write. ramWEN=1, ramREN=0.
- DACC/IACC:
  - ramREN/ramWEN are asserted combinationally from the state: data read → ramREN; data write → ramWEN; IACC → ramREN.
  - Timeout counter increments each cycle.
  - On ramstate==ACCESS: capture ramload into dmemload (data read) or imemload (instruction); writes leave dmemload unchanged. Go to DONE; strobes drop next cycle.
  - On ramstate==ERROR, or counter reaching RAM_TIMEOUT, go to ERR.
- DONE (exactly 1 cycle): assert the matching hit (dhit for DACC, ihit for IACC), then return to IDLE. Minimum latency from request in IDLE to hit = 3 cycles with zero-wait RAM (IDLE→ACC, ACC sees ACCESS→DONE, hit high).
- Back-to-back requests: the IDLE cycle after DONE re-arbitrates. A held imemREN is served after a completed data access unless a new data request is present. No request is ever served twice per hit.
- Abort: if the request for the active access drops before ACCESS, return to IDLE next cycle. No hit is issued and load registers are unchanged. A request dropping during DONE still produces the hit.
- ERR: strobes 0, mem_err=1. Stays in ERR until reset; no further hits.
- Timeout counter clears on every entry to DACC/IACC. Compare uses CNT_W bits; no wrap occurs.
- Request inputs and addresses are sampled only in IDLE. Changes during an access do not alter ramaddr or ramstore.

Test Plan:
- Reset mid-DACC with ramstate=BUSY → all outputs 0 on the same cycle nRST falls; state IDLE after release.
- imemREN=1, imemaddr=0x00000006, RAM returns 0x3C010001 on first ACCESS → ramaddr=0x00000004; ihit pulses once, 3 cycles after request; imemload=0x3C010001.
- imemREN=1 and dmemREN=1 simultaneously, dmemaddr=0x100, RAM returns 0xDEADBEEF then 0x12345678 → dhit first with dmemload=0xDEADBEEF; ihit next with imemload=0x12345678; no overlap.
- dmemWEN=1, dmemaddr=0x200, dmemstore=0xCAFEF00D, RAM BUSY 4 cycles then ACCESS → ramWEN high 5 cycles, ramstore=0xCAFEF00D; dhit 1 cycle; dmemload unchanged.
- ramstate held BUSY for RAM_TIMEOUT cycles → mem_err=1 and stays 1; no hit even after ACCESS; cleared only by nRST.
- dmemREN dropped after 2 BUSY cycles → no dhit; IDLE next cycle; a subsequent imemREN is served normally.
